// File: rtl/fifo_pkg.sv
// Shared constants and read-FSM state encoding for the FIFO read-side consumer.
// Optional parity lane is enabled by defining FIFO_RD_PARITY_EN.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH = 6;
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream of the FIFO reader.
// data_parity exists only when FIFO_RD_PARITY_EN is defined.
interface fifo_reader_if;
  import fifo_pkg::*;

  logic                  Fifo_Empty;
  logic [DATA_WIDTH-1:0] Fifo_Data_out;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_in;
  logic [CNT_WIDTH-1:0]  words_cnt;
  logic                  rd_err;
`ifdef FIFO_RD_PARITY_EN
  logic                  data_parity;

  modport master (
    input  Fifo_Empty, Fifo_Data_out, ready_in,
    output pop, data_out, valid_out, words_cnt, rd_err, data_parity
  );
  modport slave (
    output Fifo_Empty, Fifo_Data_out, ready_in,
    input  pop, data_out, valid_out, words_cnt, rd_err, data_parity
  );
`else
  modport master (
    input  Fifo_Empty, Fifo_Data_out, ready_in,
    output pop, data_out, valid_out, words_cnt, rd_err
  );
  modport slave (
    output Fifo_Empty, Fifo_Data_out, ready_in,
    input  pop, data_out, valid_out, words_cnt, rd_err
  );
`endif

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between FIFO capture and the downstream stream.
// Stores a parity bit per entry when FIFO_RD_PARITY_EN is defined.
module fifo_rd_skid
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_deq,
  output logic [1:0]            o_count,
  output logic [1:0]            o_count_next,
`ifdef FIFO_RD_PARITY_EN
  output logic                  o_parity,
`endif
  output logic                  o_overrun
);

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic                  r_head;
  logic [1:0]            r_count;
  logic                  r_overrun;

  logic       w_deq;
  logic       w_full;
  logic       w_accept;
  logic       w_drop;
  logic       w_tail;
  logic [1:0] w_count_next;

  assign w_deq  = (r_count != 2'd0) && i_ready;
  assign w_full = (r_count == 2'd2);
  // A full buffer still accepts when the head leaves in the same cycle.
  assign w_accept = i_wr && (!w_full || w_deq);
  assign w_drop   = i_wr && w_full && !w_deq;
  assign w_tail   = r_head ^ r_count[0];

  always_comb begin
    w_count_next = r_count;
    if (w_accept && !w_deq) begin
      w_count_next = r_count + 2'd1;
    end else if (!w_accept && w_deq) begin
      w_count_next = r_count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_head    <= 1'b0;
      r_count   <= 2'd0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem[w_tail] <= i_wr_data;
      end
      if (w_deq) begin
        r_head <= ~r_head;
      end
      r_count   <= w_count_next;
      r_overrun <= w_drop;
    end
  end

`ifdef FIFO_RD_PARITY_EN
  logic r_par [SKID_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par[0] <= 1'b0;
      r_par[1] <= 1'b0;
    end else if (w_accept) begin
      r_par[w_tail] <= ^i_wr_data;
    end
  end

  assign o_parity = o_valid & r_par[r_head];
`endif

  assign o_valid      = (r_count != 2'd0);
  assign o_data       = o_valid ? r_mem[r_head] : '0;
  assign o_deq        = w_deq;
  assign o_count      = r_count;
  assign o_count_next = w_count_next;
  assign o_overrun    = r_overrun;

endmodule

// File: rtl/fifo_reader.sv
// Read-side FIFO consumer: pop FSM, registered-read capture and delivered-word counter.
// Define FIFO_RD_PARITY_EN to add the data_parity output.
module fifo_reader
  import fifo_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fifo_reader_if.master  bus
);

  rd_state_e r_state;
  rd_state_e w_state_next;

  logic [CNT_WIDTH-1:0]  r_words_cnt;
  logic                  w_pop;
  logic                  w_capture;
  logic                  w_deq;
  logic [1:0]            w_count;
  logic [1:0]            w_count_next;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_valid;
  logic                  w_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fifo_Empty is only looked at outside ISSUE so it has settled after the last pop.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RD_IDLE: begin
        if (!bus.Fifo_Empty && (w_count <= 2'd1)) begin
          w_state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        w_state_next = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        if (!bus.Fifo_Empty && (w_count_next <= 2'd1)) begin
          w_state_next = RD_ISSUE;
        end else begin
          w_state_next = RD_IDLE;
        end
      end
      default: begin
        w_state_next = RD_IDLE;
      end
    endcase
  end

  always_comb begin
    w_pop     = (r_state == RD_ISSUE);
    w_capture = (r_state == RD_CAPTURE);
  end

  fifo_rd_skid u_skid (
    .clk          (clk),
    .reset        (reset),
    .i_wr         (w_capture),
    .i_wr_data    (bus.Fifo_Data_out),
    .i_ready      (bus.ready_in),
    .o_data       (w_data),
    .o_valid      (w_valid),
    .o_deq        (w_deq),
    .o_count      (w_count),
    .o_count_next (w_count_next),
`ifdef FIFO_RD_PARITY_EN
    .o_parity     (bus.data_parity),
`endif
    .o_overrun    (w_overrun)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_words_cnt <= '0;
    end else if (w_deq) begin
      r_words_cnt <= r_words_cnt + 1'b1;
    end
  end

  assign bus.pop       = w_pop;
  assign bus.data_out  = w_data;
  assign bus.valid_out = w_valid;
  assign bus.words_cnt = r_words_cnt;
  assign bus.rd_err    = w_overrun;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed + random bench for fifo_reader against a queue-based FIFO and stream model.
// Parity checks are compiled in when FIFO_RD_PARITY_EN is defined.
module tb_fifo_reader;
  import fifo_pkg::*;

  logic clk;
  logic reset;

  fifo_reader_if u_if ();

  fifo_reader u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DATA_WIDTH-1:0] fq [$];
  logic [DATA_WIDTH-1:0] exp_q [$];
  int pop_cnt      = 0;
  int pop_on_empty = 0;
  int hs_model     = 0;
  bit mon_en       = 1'b0;
  bit prev_stall   = 1'b0;
  logic [DATA_WIDTH-1:0] prev_data = '0;

  logic                  s_valid;
  logic                  s_pop;
  logic [DATA_WIDTH-1:0] s_data;
  logic [CNT_WIDTH-1:0]  s_cnt;
  logic                  s_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_WIDTH-1:0] d);
    fq.push_back(d);
    exp_q.push_back(d);
  endtask

  // One clock: sample and check at negedge, then model the FIFO just after posedge.
  task automatic tick();
    logic l_pop;
    @(negedge clk);
    s_valid = u_if.valid_out;
    s_pop   = u_if.pop;
    s_data  = u_if.data_out;
    s_cnt   = u_if.words_cnt;
    s_err   = u_if.rd_err;
    l_pop   = u_if.pop;
    if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, s_valid}, 32'd1);
        check("hold_data", {26'd0, s_data}, {26'd0, prev_data});
      end
      check("words_cnt", {24'd0, s_cnt}, {24'd0, hs_model[7:0]});
      check("rd_err", {31'd0, s_err}, 32'd0);
`ifdef FIFO_RD_PARITY_EN
      if (!s_valid) check("parity_idle", {31'd0, u_if.data_parity}, 32'd0);
`endif
      if (s_valid && u_if.ready_in) begin
        check("word_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          check("stream_data", {26'd0, s_data}, {26'd0, exp_q[0]});
`ifdef FIFO_RD_PARITY_EN
          check("parity", {31'd0, u_if.data_parity}, {31'd0, ^exp_q[0]});
`endif
          void'(exp_q.pop_front());
        end
        hs_model++;
      end
      prev_stall = s_valid && !u_if.ready_in;
      prev_data  = s_data;
    end
    @(posedge clk);
    #1;
    if (l_pop) begin
      pop_cnt++;
      if (fq.size() == 0) pop_on_empty++;
      else u_if.Fifo_Data_out = fq.pop_front();
    end
    u_if.Fifo_Empty = (fq.size() == 0);
  endtask

  task automatic drain(input string tag);
    int n;
    u_if.ready_in = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || s_valid) && n < 3000) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    int pops0;
    int n;
    reset            = 1'b1;
    u_if.ready_in    = 1'b0;
    u_if.Fifo_Empty  = 1'b1;
    u_if.Fifo_Data_out = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_valid", {31'd0, s_valid}, 32'd0);
    check("rst_data", {26'd0, s_data}, 32'd0);
    check("rst_pop", {31'd0, s_pop}, 32'd0);
    check("rst_cnt", {24'd0, s_cnt}, 32'd0);
    check("rst_err", {31'd0, s_err}, 32'd0);
    mon_en = 1'b1;

    // Empty FIFO: no pops.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_pop", {31'd0, s_pop}, 32'd0);
    end
    check("idle_valid", {31'd0, s_valid}, 32'd0);
    check("idle_cnt", {24'd0, s_cnt}, 32'd0);

    // Single word: latency and single pop.
    u_if.ready_in = 1'b1;
    pops0 = pop_cnt;
    push(6'h15);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("lat_pop_%0d", i), {31'd0, s_pop}, {31'd0, i == 3});
      check($sformatf("lat_valid_%0d", i), {31'd0, s_valid}, {31'd0, i == 5});
    end
    check("single_data", {26'd0, s_data}, 32'h15);
    repeat (4) tick();
    check("single_pops", pop_cnt - pops0, 32'd1);
    check("single_cnt", {24'd0, s_cnt}, 32'd1);

    // Four words with downstream stalled: buffer fills after two pops.
    u_if.ready_in = 1'b0;
    pops0 = pop_cnt;
    push(6'h01); tick();
    push(6'h02); tick();
    push(6'h03); tick();
    push(6'h04);
    repeat (20) tick();
    check("stall_pops", pop_cnt - pops0, 32'd2);
    check("stall_valid", {31'd0, s_valid}, 32'd1);
    check("stall_head", {26'd0, s_data}, 32'h01);
    drain("drain4");
    check("cnt_after4", {24'd0, s_cnt}, 32'd5);

    // Parity vectors (checked by the monitor when the lane exists).
    push(6'h07);
    push(6'h03);
    drain("drain_par");

    // Random stream: toggling ready, then random ready; enough words to wrap words_cnt.
    for (int i = 0; i < 700; i++) begin
      if (i < 400) u_if.ready_in = ~u_if.ready_in;
      else u_if.ready_in = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) push(6'($urandom));
      tick();
    end
    drain("drain_rand");
    check("cnt_rand", {24'd0, s_cnt}, {24'd0, hs_model[7:0]});
    check("no_pop_empty", pop_on_empty, 32'd0);

    // Reset while the popped word is being captured.
    mon_en = 1'b0;
    u_if.ready_in = 1'b0;
    fq.push_back(6'h2A);
    n = 0;
    s_pop = 1'b0;
    while (!s_pop && n < 10) begin
      tick();
      n++;
    end
    check("inflight_pop", {31'd0, s_pop}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("midrst_valid", {31'd0, s_valid}, 32'd0);
    check("midrst_cnt", {24'd0, s_cnt}, 32'd0);
    check("midrst_data", {26'd0, s_data}, 32'd0);
    exp_q.delete();
    hs_model   = 0;
    prev_stall = 1'b0;
    mon_en     = 1'b1;
    u_if.ready_in = 1'b1;
    pops0 = pop_cnt;
    repeat (10) tick();
    check("post_rst_valid", {31'd0, s_valid}, 32'd0);
    check("post_rst_pops", pop_cnt - pops0, 32'd0);
    check("post_rst_cnt", {24'd0, s_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
